matmul_apb_sequencer: RTL
=========================

// Module: matmul_apb_sequencer
// PURPOSE
//  Synthesizable APB master that replays a host-loaded command list into a matmul slave: operand/config
//  writes, start, poll for done, result reads. Sits between a local host port and the matmul APB slave;
//  replaces bench-driven APB traffic. Adds replay, done-wait with timeout, pslverr abort, read backpressure.
// PARAMETERS
//  DATA_WIDTH   8     matmul element width; used only to size STRB_WIDTH
//  BUS_WIDTH    32    APB data width (pwdata/prdata)
//  ADDR_WIDTH   16    APB address width
//  CMD_DEPTH    16    command buffer entries (power of 2, >=2)
//  TIMEOUT_CYC  4096  max cycles waiting on pready_i or mm_done_i before abort
//  STRB_WIDTH   BUS_WIDTH/DATA_WIDTH  (derived, localparam)
// PORTS
//  clk_i        in   1            clock
//  rst_i        in   1            synchronous reset, active-high
//  cmd_valid_i  in   1            host command push valid
//  cmd_ready_o  out  1            buffer accepts push (not full, state IDLE)
//  cmd_i        in   cmd_t        {op[1:0], addr, data, strb}
//  clear_i      in   1            empty the command buffer (IDLE only; ignored otherwise)
//  start_i      in   1            run the list from entry 0
//  busy_o       out  1            sequence in progress
//  done_o       out  1            1-cycle pulse: sequence finished without error
//  err_o        out  1            sticky error flag, cleared by start_i or rst_i
//  err_code_o   out  2            err_e: NONE, SLVERR, TIMEOUT
//  rd_valid_o   out  1            read result valid
//  rd_ready_i   in   1            read result consumed
//  rd_data_o    out  BUS_WIDTH    read result data
//  psel_o, penable_o, pwrite_o out 1   APB master controls
//  paddr_o      out  ADDR_WIDTH   APB address
//  pwdata_o     out  BUS_WIDTH    APB write data
//  pstrb_o      out  STRB_WIDTH   APB strobe
//  pready_i, pslverr_i in 1       APB slave response
//  prdata_i     in   BUS_WIDTH    APB read data
//  mm_done_i    in   1            matmul done_o
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready_o=1; buffer count=0; state IDLE; err_code_o=NONE.
//  Ops: WR=APB write, RD=APB read then push result, WAIT=hold until mm_done_i=1, END=finish sequence.
//  Push: cmd_valid_i&cmd_ready_o writes entry at wr_ptr, count+1. Full (count==CMD_DEPTH) -> cmd_ready_o=0.
//  clear_i&cmd_valid_i same cycle: clear wins, push dropped. Buffer retained after run (replayable).
//  FSM: IDLE -> FETCH -> {SETUP -> ACCESS -> (RDPUSH) | WAITD} -> FETCH ... -> IDLE / ERROR.
//   IDLE: start_i & count>0 -> FETCH, rd_ptr=0, busy_o=1, err cleared. start_i with count==0 -> done_o pulse next cycle.
//   FETCH: 1-cycle registered buffer read. Op END or rd_ptr==count -> IDLE, done_o pulse, busy_o=0.
//   SETUP: psel_o=1, penable_o=0, paddr/pwdata/pstrb/pwrite stable; 1 cycle -> ACCESS.
//   ACCESS: psel_o=penable_o=1, all APB outputs held until pready_i. pready_i&pslverr_i -> ERROR(SLVERR).
//     pready_i&!pslverr_i: WR -> FETCH(rd_ptr+1); RD -> latch prdata_i, RDPUSH. psel_o/penable_o drop to 0 the cycle after pready_i.
//   RDPUSH: rd_valid_o=1, rd_data_o stable until rd_ready_i; then FETCH(rd_ptr+1). No APB traffic meanwhile.
//   WAITD: mm_done_i=1 -> FETCH(rd_ptr+1); mm_done_i may be a pulse, sampled every cycle, including the entry cycle.
//   ERROR: err_o=1, busy_o=0, APB idle, no done_o; returns to IDLE next cycle; err_code_o held until next start_i.
//  Timeout: counter cleared entering ACCESS/WAITD; reaching TIMEOUT_CYC-1 without pready_i/mm_done_i -> ERROR(TIMEOUT).
//  Back-to-back APB accesses: min 1 idle cycle (FETCH) between transfers; WR command = 3 cycles with pready_i tied 1.
//  start_i while busy_o=1: ignored. rst_i mid-transfer: APB outputs 0 next edge, transfer abandoned, buffer emptied.
//  Widths: rd_ptr/wr_ptr $clog2(CMD_DEPTH); count $clog2(CMD_DEPTH)+1; timeout counter $clog2(TIMEOUT_CYC)+1.
// STRUCTURE
//  matmul_pkg additions: cmd_op_e {CMD_WR,CMD_RD,CMD_WAIT,CMD_END}, cmd_t packed struct, err_e, seq_state_e.
//  Sub-module matmul_cmd_buf: CMD_DEPTH x cmd_t storage, write port + registered read port, count/full.
//  Top holds FSM, timeout counter, APB output registers, read result register.
// TESTING
//  Load {WR 0x0000 0x1, WR 0x0004 0x2, RD 0x0008, END}, pready=1 -> 2 writes, 1 read, rd_data_o=slave value, done_o 1 pulse.
//  Slave pready delayed 3 cycles -> penable_o/paddr_o/pwdata_o stable 4 ACCESS cycles, no extra transfer.
//  RD with rd_ready_i=0 for 10 cycles -> rd_valid_o held, rd_data_o stable, psel_o=0 throughout, then resumes.
//  WR with pslverr_i=1 -> err_o=1, err_code_o=SLVERR, no done_o, remaining commands not issued; replay start_i clears err_o.
//  WAIT, mm_done_i never asserted, TIMEOUT_CYC=16 -> err_code_o=TIMEOUT 16 cycles after WAITD entry.
//  Push 17 entries at CMD_DEPTH=16 -> 17th refused (cmd_ready_o=0); rst_i mid-ACCESS -> all APB outputs 0, count=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types for the matmul APB command sequencer
// Exports cmd_op_e, cmd_t (host command word), err_e (abort cause), seq_state_e (sequencer FSM).
package matmul_pkg;
   localparam int CMD_ADDR_W = 16;
   localparam int CMD_DATA_W = 32;
   localparam int CMD_STRB_W = 4;
   typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_WAIT, CMD_END} cmd_op_e;
   typedef struct packed {
      cmd_op_e                op;
      logic [CMD_ADDR_W-1:0]  addr;
      logic [CMD_DATA_W-1:0]  data;
      logic [CMD_STRB_W-1:0]  strb;
   } cmd_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_SLVERR, ERR_TIMEOUT} err_e;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_RDPUSH, S_WAITD, S_ERROR} seq_state_e;
endpackage

// File: rtl/matmul_cmd_buf.sv
// matmul_cmd_buf: command list storage with a write port and a registered read port
// Ports: clk_i/rst_i, push/clear (clear wins), wdata, raddr -> rdata (one cycle later), count, full.
module matmul_cmd_buf import matmul_pkg::*; #(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic             clear,
   input  cmd_t             wdata,
   input  logic [PTR_W-1:0] raddr,
   output cmd_t             rdata,
   output logic [CNT_W-1:0] count,
   output logic             full
);
   logic [PTR_W-1:0] wr_ptr;
   cmd_t mem [DEPTH];
   assign full = count == CNT_W'(DEPTH);
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + 1'b1;
         count  <= count + 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push && !clear) mem[wr_ptr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/matmul_apb_sequencer.sv
// matmul_apb_sequencer: APB master replaying a host-loaded command list into the matmul slave
// Host: cmd_valid_i/cmd_ready_o/cmd_i push, clear_i, start_i; status busy_o, done_o, err_o, err_code_o.
// Reads: rd_valid_o/rd_ready_i/rd_data_o. APB: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
// pready_i, pslverr_i, prdata_i. mm_done_i releases WAIT commands.
module matmul_apb_sequencer import matmul_pkg::*; #(
   parameter  int DATA_WIDTH  = 8,
   parameter  int BUS_WIDTH   = 32,
   parameter  int ADDR_WIDTH  = 16,
   parameter  int CMD_DEPTH   = 16,
   parameter  int TIMEOUT_CYC = 4096,
   localparam int STRB_WIDTH  = BUS_WIDTH / DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  cmd_t                  cmd_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output err_e                  err_code_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [BUS_WIDTH-1:0]  rd_data_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [BUS_WIDTH-1:0]  pwdata_o,
   output logic [STRB_WIDTH-1:0] pstrb_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [BUS_WIDTH-1:0]  prdata_i,
   input  logic                  mm_done_i
);
   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
   seq_state_e state;
   cmd_t q;
   logic [CNT_W-1:0] idx, count;
   logic [PTR_W-1:0] raddr;
   logic [TMO_W-1:0] tmo;
   logic full, slv_err, tmo_err;
   // idx is one bit wider than the buffer pointer so a full list without END ends at idx==count
   // instead of wrapping back to entry 0. The buffer pre-reads the entry the next FETCH will use.
   assign raddr       = state == S_IDLE ? '0 : idx[PTR_W-1:0] + 1'b1;
   assign cmd_ready_o = state == S_IDLE && !full;
   assign slv_err     = state == S_ACCESS && pready_i && pslverr_i;
   assign tmo_err     = tmo == TMO_W'(TIMEOUT_CYC - 1) &&
                        ((state == S_ACCESS && !pready_i) || (state == S_WAITD && !mm_done_i));
   matmul_cmd_buf #(.DEPTH(CMD_DEPTH)) u_buf (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (cmd_valid_i && cmd_ready_o),
      .clear (clear_i && state == S_IDLE),
      .wdata (cmd_i),
      .raddr (raddr),
      .rdata (q),
      .count (count),
      .full  (full)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         idx        <= '0;
         tmo        <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         psel_o     <= 1'b0;
         penable_o  <= 1'b0;
         pwrite_o   <= 1'b0;
         paddr_o    <= '0;
         pwdata_o   <= '0;
         pstrb_o    <= '0;
      end else begin
         done_o <= 1'b0;
         tmo    <= tmo + 1'b1;
         case (state)
            S_IDLE: if (start_i) begin
               err_o      <= 1'b0;
               err_code_o <= ERR_NONE;
               idx        <= '0;
               if (count == '0) done_o <= 1'b1;
               else begin
                  state  <= S_FETCH;
                  busy_o <= 1'b1;
               end
            end
            S_FETCH: if (q.op == CMD_END || idx == count) begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end else if (q.op == CMD_WAIT) begin
               state <= S_WAITD;
               tmo   <= '0;
            end else begin
               state    <= S_SETUP;
               psel_o   <= 1'b1;
               pwrite_o <= q.op == CMD_WR;
               paddr_o  <= ADDR_WIDTH'(q.addr);
               pwdata_o <= BUS_WIDTH'(q.data);
               pstrb_o  <= STRB_WIDTH'(q.strb);
            end
            S_SETUP: begin
               state     <= S_ACCESS;
               penable_o <= 1'b1;
               tmo       <= '0;
            end
            S_ACCESS: if (pready_i) begin
               psel_o    <= 1'b0;
               penable_o <= 1'b0;
               if (!pslverr_i && pwrite_o) begin
                  state <= S_FETCH;
                  idx   <= idx + 1'b1;
               end else if (!pslverr_i) begin
                  state      <= S_RDPUSH;
                  rd_valid_o <= 1'b1;
                  rd_data_o  <= prdata_i;
               end
            end
            S_RDPUSH: if (rd_ready_i) begin
               state      <= S_FETCH;
               rd_valid_o <= 1'b0;
               idx        <= idx + 1'b1;
            end
            S_WAITD: if (mm_done_i) begin
               state <= S_FETCH;
               idx   <= idx + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
         // Aborts override whatever the state case chose and leave the bus idle.
         if (slv_err || tmo_err) begin
            state      <= S_ERROR;
            err_o      <= 1'b1;
            err_code_o <= slv_err ? ERR_SLVERR : ERR_TIMEOUT;
            busy_o     <= 1'b0;
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
         end
      end
   end
endmodule
